// File: rtl/bomb_pkg.sv
// Shared constants, FSM encoding and helpers for the bomb placement scheduler.
package bomb_pkg;

    localparam int MAX_BOMBS  = 2;
    localparam int FUSE_TICKS = 3;
    localparam logic [3:0] GRID_MIN = 4'd1;
    localparam logic [3:0] GRID_MAX = 4'd8;

    localparam logic [1:0] MAX_COUNT = 2'(MAX_BOMBS);
    localparam logic [1:0] LAST_AGE  = 2'(FUSE_TICKS - 1);
    localparam logic [1:0] NEW_BOMB  = 2'd1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, ADV} state_t;
    typedef enum logic {PLAYER_A = 1'b0, PLAYER_B = 1'b1} player_t;

    function automatic logic in_grid(input logic [3:0] c);
        return (c >= GRID_MIN) && (c <= GRID_MAX);
    endfunction

endpackage

// File: rtl/bomb_scheduler_if.sv
// Request/bomb-map bundle between the scheduler (slave) and its environment (master).
interface bomb_scheduler_if;

    logic       tick;
    logic       reqA, reqB;
    logic [3:0] playerAx, playerAy, playerBx, playerBy;
    logic [1:0] cellState;
    logic [3:0] rdX, rdY;
    logic       wrEn;
    logic [3:0] wrX, wrY;
    logic [1:0] wrState;
    logic       advance;
    logic       grantA, grantB, denyA, denyB;
    logic [1:0] bombsA, bombsB;

    modport slave (
        input  tick, reqA, reqB, playerAx, playerAy, playerBx, playerBy, cellState,
        output rdX, rdY, wrEn, wrX, wrY, wrState, advance,
               grantA, grantB, denyA, denyB, bombsA, bombsB
    );

    modport master (
        output tick, reqA, reqB, playerAx, playerAy, playerBx, playerBy, cellState,
        input  rdX, rdY, wrEn, wrX, wrY, wrState, advance,
               grantA, grantB, denyA, denyB, bombsA, bombsB
    );

endinterface

// File: rtl/bomb_slot_tracker.sv
// Per-player live-bomb slots: allocate on placement, age on every advance, free at fuse end.
module bomb_slot_tracker
    import bomb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       alloc,
    input  logic       advance,
    output logic [1:0] count
);

    logic [MAX_BOMBS-1:0] valid;
    logic [1:0]           age [MAX_BOMBS];
    logic [MAX_BOMBS-1:0] free_sel;
    logic                 found;

    // NOTE: every variable gets a default before the loop, so no path can infer a latch.
    always_comb begin
        free_sel = '0;
        found    = 1'b0;
        for (int i = 0; i < MAX_BOMBS; i++) begin
            if (!valid[i] && !found) begin
                free_sel[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
            // NOTE: ages are cleared too, so a reused slot never inherits a stale fuse.
            for (int i = 0; i < MAX_BOMBS; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_BOMBS; i++) begin
                if (advance && valid[i]) begin
                    if (age[i] == LAST_AGE) begin
                        valid[i] <= 1'b0;
                        age[i]   <= '0;
                    end else begin
                        age[i] <= age[i] + 2'd1;
                    end
                end else if (alloc && free_sel[i]) begin
                    valid[i] <= 1'b1;
                    age[i]   <= '0;
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < MAX_BOMBS; i++) count = count + 2'(valid[i]);
    end

endmodule

// File: rtl/bomb_scheduler.sv
// Round-robin bomb placement arbiter with tick-driven fuse ageing of each player's bombs.
module bomb_scheduler
    import bomb_pkg::*;
(
    input logic             clk,
    input logic             rst,
    bomb_scheduler_if.slave bus
);

    state_t     state, next_state;
    player_t    rr_ptr, winner;
    logic       pend_tick;
    logic [3:0] rd_x, rd_y, wr_x, wr_y;
    logic [1:0] bombs_a, bombs_b, win_count;
    logic       pick_b, deny_hit;
    logic       wr_en_d, advance_d, grant_a_d, grant_b_d, deny_a_d, deny_b_d;
    logic       wr_en_q, advance_q, grant_a_q, grant_b_q, deny_a_q, deny_b_q;

    assign pick_b    = bus.reqB && (!bus.reqA || rr_ptr == PLAYER_B);
    assign win_count = (winner == PLAYER_A) ? bombs_a : bombs_b;
    assign deny_hit  = (bus.cellState != 2'd0) || !in_grid(rd_x) || !in_grid(rd_y)
                       || (win_count == MAX_COUNT);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.tick || pend_tick)    next_state = ADV;
                else if (bus.reqA || bus.reqB) next_state = READ;
            end
            READ:    next_state = deny_hit ? IDLE : WRITE;
            WRITE:   next_state = IDLE;
            ADV:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decided one state ahead and registered, so they line up with WRITE/ADV.
    always_comb begin
        wr_en_d   = 1'b0;
        grant_a_d = 1'b0;
        grant_b_d = 1'b0;
        deny_a_d  = 1'b0;
        deny_b_d  = 1'b0;
        advance_d = (next_state == ADV);
        if (state == READ && next_state == WRITE) begin
            wr_en_d   = 1'b1;
            grant_a_d = (winner == PLAYER_A);
            grant_b_d = (winner == PLAYER_B);
        end
        if (state == READ && next_state == IDLE) begin
            deny_a_d = (winner == PLAYER_A);
            deny_b_d = (winner == PLAYER_B);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en_q   <= 1'b0;
            advance_q <= 1'b0;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            deny_a_q  <= 1'b0;
            deny_b_q  <= 1'b0;
            wr_x      <= '0;
            wr_y      <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            advance_q <= advance_d;
            grant_a_q <= grant_a_d;
            grant_b_q <= grant_b_d;
            deny_a_q  <= deny_a_d;
            deny_b_q  <= deny_b_d;
            if (wr_en_d) begin
                wr_x <= rd_x;
                wr_y <= rd_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_x      <= '0;
            rd_y      <= '0;
            winner    <= PLAYER_A;
            rr_ptr    <= PLAYER_A;
            pend_tick <= 1'b0;
        end else begin
            if (state == IDLE && next_state == READ) begin
                winner <= pick_b ? PLAYER_B : PLAYER_A;
                rd_x   <= pick_b ? bus.playerBx : bus.playerAx;
                rd_y   <= pick_b ? bus.playerBy : bus.playerAy;
            end
            if (state == WRITE) rr_ptr <= (rr_ptr == PLAYER_A) ? PLAYER_B : PLAYER_A;
            if (state == ADV)
                pend_tick <= 1'b0;
            else if (bus.tick && (state == READ || state == WRITE))
                pend_tick <= 1'b1;
        end
    end

    bomb_slot_tracker u_slots_a (
        .clk     (clk),
        .rst     (rst),
        .alloc   (state == WRITE && winner == PLAYER_A),
        .advance (state == ADV),
        .count   (bombs_a)
    );

    bomb_slot_tracker u_slots_b (
        .clk     (clk),
        .rst     (rst),
        .alloc   (state == WRITE && winner == PLAYER_B),
        .advance (state == ADV),
        .count   (bombs_b)
    );

    assign bus.rdX     = rd_x;
    assign bus.rdY     = rd_y;
    assign bus.wrEn    = wr_en_q;
    assign bus.wrX     = wr_x;
    assign bus.wrY     = wr_y;
    assign bus.wrState = NEW_BOMB;
    assign bus.advance = advance_q;
    assign bus.grantA  = grant_a_q;
    assign bus.grantB  = grant_b_q;
    assign bus.denyA   = deny_a_q;
    assign bus.denyB   = deny_b_q;
    assign bus.bombsA  = bombs_a;
    assign bus.bombsB  = bombs_b;

endmodule

// File: doc/bomb_scheduler.md
BOMB_SCHEDULER -- requirements
Module: bomb_scheduler

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset; synchronous and active-low.
REQ-003 tick  in  1  one-cycle strobe at the bomb-advance rate (1 Hz equivalent).
REQ-004 reqA, reqB  in  1  level bomb-placement requests; held until the matching grant or deny.
REQ-005 playerAx, playerAy, playerBx, playerBy  in  4  current player cell coordinates.
REQ-006 cellState  in  2  bomb-map content at (rdX, rdY); valid the cycle after the address is driven.
REQ-007 rdX, rdY  out  4  bomb-map read address.
REQ-008 wrEn  out  1  bomb-map write strobe.
REQ-009 wrX, wrY  out  4  write address.
REQ-010 wrState  out  2  write data; always 1 (new bomb).
REQ-011 advance  out  1  one-cycle strobe commanding the bomb map to advance one state.
REQ-012 grantA, grantB, denyA, denyB  out  1  one-cycle placement outcome pulses.
REQ-013 bombsA, bombsB  out  2  live bomb count per player.
REQ-014 Parameters: MAX_BOMBS = 2 (live bombs per player); FUSE_TICKS = 3 (ticks from placement to slot release); GRID_MIN = 1 and GRID_MAX = 8 (playable cell range).

Function
REQ-015 FSM states SHALL be IDLE, READ, WRITE and ADV.
REQ-016 IDLE transitions:
- tick asserted or pendTick set -> ADV; ADV takes priority over requests.
- otherwise, any request pending -> latch the winner's coordinates onto rdX/rdY, go to READ.
REQ-017 Arbitration SHALL be round-robin.
- rrPtr selects the preferred player when both request.
- rrPtr resets to A.
- rrPtr moves to the other player after every grant, but not after a deny.
REQ-018 READ SHALL deny the winner (pulse denyX, return to IDLE) if any of the following holds:
- cellState != 0.
- Either latched coordinate is outside GRID_MIN..GRID_MAX.
- The winner's bomb count equals MAX_BOMBS.
Otherwise READ SHALL go to WRITE.
REQ-019 WRITE SHALL, in one cycle:
- assert wrEn with wrX/wrY = latched coordinates and wrState = 1;
- pulse grantX and increment bombsX;
- store the cell in a free owner slot with age 0;
- toggle rrPtr;
- return to IDLE.
REQ-020 ADV SHALL, in one cycle:
- assert advance and clear pendTick;
- increment the age of every occupied slot;
- free any slot whose age reaches FUSE_TICKS and decrement that owner's count;
- return to IDLE.
REQ-021 Latency: a request seen in IDLE at cycle N SHALL produce grant/deny at cycle N+2 (WRITE or READ), with no tick intervening.
REQ-022 A tick arriving while the FSM is in READ or WRITE SHALL set pendTick; further ticks while pendTick is set collapse into it.
REQ-023 A tick in the same cycle as IDLE sees a request SHALL win; the request remains pending and is served after ADV.
REQ-024 Both players requesting the same cell: the winner is granted, and the loser is subsequently denied because cellState reads nonzero.
REQ-025 A player's count SHALL never exceed MAX_BOMBS or underflow below 0; WRITE and ADV are mutually exclusive, so increment and decrement never coincide.
REQ-026 wrEn, advance, and all grant/deny outputs SHALL be low in every state except where REQ-018 to REQ-020 assert them.
REQ-027 rdX and rdY SHALL hold their last value outside READ.

Reset
REQ-028 With rst low at a rising edge, the block SHALL reset as follows:
- FSM = IDLE; pendTick = 0; rrPtr = A;
- all slots freed; bombsA = bombsB = 0;
- all strobes and pulses = 0; rdX/rdY/wrX/wrY = 0; wrState = 1.
REQ-029 Reset mid-operation (READ or WRITE) SHALL abandon the in-flight request with no grant, deny or write issued.

Structure
REQ-030 MAX_BOMBS, FUSE_TICKS, GRID_MIN, GRID_MAX and the FSM state encoding SHALL live in shared package bomb_pkg.
REQ-031 Per-player slot storage and ageing SHALL be a sub-module bomb_slot_tracker (slots, ages, count, alloc and advance ports), instantiated twice.

Verification
REQ-032 Single request: reqA with A at (2,3), cellState = 0 -> grantA at cycle +2, wrEn with (2,3, state 1), bombsA = 1.
REQ-033 Simultaneous requests from reset, A at (4,4), B at (5,5) -> A granted first, then B granted; rrPtr ends on A.
REQ-034 Limit: three placements by A on free cells -> first two granted, third denied; bombsA stays 2.
REQ-035 Expiry: place a bomb, then issue 3 ticks -> 3 advance pulses; bombsA returns to 0 after the third; placing again is then granted.
REQ-036 Conflict and boundary:
- tick during READ -> advance issued immediately after the grant cycle;
- request at (0,5) or (9,2) -> deny;
- rst low in READ -> no grant, counts 0.
